traf_ctl_gen: RTL and testbench
===============================

Name: traf_ctl_gen

Overview:
Parametrised two-road traffic-light controller, the successor to the fixed-timing XYF controller. It adds per-road green times, a pedestrian-request green truncation, and a night mode that flashes both yellows. It also adds an all-red clearance phase and drives a 4-digit multiplexed 7-segment countdown display. It sits at the top of the traffic-control FPGA design, driving the lamps and the display directly.

Parameters:
CLK_DIV, 50000000, clock cycles per 1-second tick (>=2)
GREEN1_T, 30, road-1 green duration in seconds (1..99)
GREEN2_T, 20, road-2 green duration in seconds (1..99)
YELLOW_T, 3, yellow duration in seconds (1..99)
ALL_RED_T, 2, all-red clearance duration in seconds (1..99)
PED_MIN, 5, remaining green seconds after a pedestrian request (1..99)
SCAN_DIV, 50000, clock cycles per display digit step (>=1)
SEG_ACTIVE_LOW, 0, 1 inverts Seg outputs

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-high reset
Night  in  1  level; 1 selects flashing-yellow night mode
Ped_req  in  2  bit0 requests road 1 to stop; bit1 requests road 2 to stop (levels)
Red1, Yellow1, Green1  out  1 each  road-1 lamps, active-high
Red2, Yellow2, Green2  out  1 each  road-2 lamps, active-high
Seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-high unless SEG_ACTIVE_LOW
Sl  out  4  digit select, one-hot, active-high

Behaviour:
- Tick prescaler
  - Counts 0..CLK_DIV-1 and wraps.
  - tick=1 for one cycle when the prescaler equals CLK_DIV-1.
  - Reset clears the prescaler, so the first tick occurs CLK_DIV cycles after Reset falls.
- States and lamps
  - G1 (Green1, Red2), phase number 1
  - Y1 (Yellow1, Red2), phase 2
  - AR1 (Red1, Red2), phase 3
  - G2 (Red1, Green2), phase 4
  - Y2 (Red1, Yellow2), phase 5
  - AR2 (Red1, Red2), phase 6
  - NIGHT (Yellow1=Yellow2=blink, all other lamps 0)
- Sequence: G1→Y1→AR1→G2→Y2→AR2→G1.
- Phase counter cnt (7 bits)
  - Loaded with the phase duration on entry.
  - On a tick with cnt>1, cnt decrements.
  - On a tick with cnt==1, the state advances and cnt is loaded with the next phase duration.
  - Each phase therefore lasts exactly duration*CLK_DIV cycles.
- Pedestrian truncation
  - Applies in G1 with Ped_req[0]=1, or in G2 with Ped_req[1]=1, when cnt>PED_MIN.
  - cnt is set to PED_MIN on the next edge.
  - This takes priority over a coincident tick decrement.
  - It has no effect when cnt<=PED_MIN, and no effect in any other state.
- Night mode
  - Night=1 in any state forces NIGHT on the next edge; this has priority over everything except Reset.
  - In NIGHT, blink toggles on every tick; blink is 0 on entry.
  - On the first cycle with Night=0 in NIGHT, the state goes to AR2 with cnt=ALL_RED_T, so road 1 gets green next.
- Display
  - Scan counter steps the digit every SCAN_DIV cycles in the order 0,1,2,3,0.
  - Sl=4'b0001 selects digit 0.
  - Digit 3 = tens of cnt and digit 2 = units of cnt (leading zero shown); digit 1 is blank; digit 0 is the phase number.
  - Decimal point is always off.
  - Codes: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, blank=0x00.
  - In NIGHT all digits are blank, and the scan continues.
  - Seg is combinational from the registered cnt, state and scan index.
- Reset (synchronous, any time, including mid-phase or in NIGHT)
  - State G1, cnt=GREEN1_T, prescaler=0, blink=0, scan=0.
  - Outputs: Green1=1, Red2=1, other lamps 0, Sl=4'b0001, Seg = code of phase 1 (0x06, inverted if SEG_ACTIVE_LOW).
- Exactly one lamp per road is lit in every non-NIGHT state; Green1 and Green2 are never 1 together.

Test Plan:
(Params for all: CLK_DIV=4, GREEN1_T=5, GREEN2_T=3, YELLOW_T=2, ALL_RED_T=1, PED_MIN=2, SCAN_DIV=2.)
- Reset sequence: pulse Reset, then free-run.
  - G1 lasts 20 cycles, Y1 8, AR1 4, G2 12, Y2 8, AR2 4.
  - G1 is re-entered 56 cycles after Reset falls.
  - Lamp one-hot check every cycle.
- Countdown display: in G1, sample digits over the scan.
  - Digit 3=0x3F, digit 2 goes 0x6D,0x66,0x4F,0x5B,0x06 on successive seconds.
  - Digit 1=0x00, digit 0=0x06.
  - Sl rotates 0001→0010→0100→1000 every 2 cycles.
- Pedestrian truncation: assert Ped_req[0] in G1 while cnt=5, coincident with a tick → cnt=2 next cycle, and Y1 is entered exactly 2 ticks later.
  - Ped_req[0] with cnt=2 → no change.
  - Ped_req[1] in G1 → no change.
- Night mode: assert Night mid-G2 → next cycle all lamps 0 except both yellows.
  - Yellows toggle every 4 cycles and Seg=0x00.
  - Deassert Night → AR2 for 4 cycles, then G1 with cnt=5.
- Reset mid-operation: assert Reset in Y2 and in NIGHT → next cycle G1 state, cnt=5, Sl=0001, Seg=0x06; no residual blink.
- SEG_ACTIVE_LOW=1 rerun of the display scenario → every Seg value is the bitwise inverse (e.g. 5 → 0x92, blank → 0xFF).

Source files
------------

// File: rtl/traf_ctl_gen.sv
// traf_ctl_gen
//   Two-road traffic-light controller with per-road green times and pedestrian
//   green truncation. It also provides an all-red clearance phase, a
//   flashing-yellow night mode and a 4-digit multiplexed 7-segment countdown.
//
// Ports
//   Clk                      system clock
//   Reset                    synchronous, active-high reset
//   Night                    level, 1 selects flashing-yellow night mode
//   Ped_req[1:0]             bit0 asks road 1 to stop, bit1 asks road 2 to stop
//   Red1/Yellow1/Green1      road-1 lamps, active-high, registered
//   Red2/Yellow2/Green2      road-2 lamps, active-high, registered
//   Seg[7:0]                 segments {dp,g,f,e,d,c,b,a}, inverted if SEG_ACTIVE_LOW
//   Sl[3:0]                  one-hot digit select, 4'b0001 is digit 0
module traf_ctl_gen #(
  parameter int CLK_DIV        = 50000000,
  parameter int GREEN1_T       = 30,
  parameter int GREEN2_T       = 20,
  parameter int YELLOW_T       = 3,
  parameter int ALL_RED_T      = 2,
  parameter int PED_MIN        = 5,
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Night,
  input  logic [1:0] Ped_req,
  output logic       Red1,
  output logic       Yellow1,
  output logic       Green1,
  output logic       Red2,
  output logic       Yellow2,
  output logic       Green2,
  output logic [7:0] Seg,
  output logic [3:0] Sl
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [2:0] {
    ST_G1, ST_Y1, ST_AR1, ST_G2, ST_Y2, ST_AR2, ST_NIGHT
  } state_e;

  // Lamp vector order: {Red1, Yellow1, Green1, Red2, Yellow2, Green2}
  localparam logic [5:0] LAMPS_G1 = 6'b001_100;

  logic [PW-1:0] presc_q;
  logic          tick;
  logic [SW-1:0] scanCnt_q;
  logic [1:0]    scan_q;

  state_e        state_q, state_d;
  logic [6:0]    cnt_q, cnt_d;
  logic          blink_q, blink_d;
  logic [5:0]    lamps_q;

  // Phase duration loaded into cnt on entry to a phase.
  function automatic logic [6:0] durOf(input state_e s);
    case (s)
      ST_G1:   durOf = 7'(GREEN1_T);
      ST_Y1:   durOf = 7'(YELLOW_T);
      ST_AR1:  durOf = 7'(ALL_RED_T);
      ST_G2:   durOf = 7'(GREEN2_T);
      ST_Y2:   durOf = 7'(YELLOW_T);
      default: durOf = 7'(ALL_RED_T);
    endcase
  endfunction

  function automatic state_e nextOf(input state_e s);
    case (s)
      ST_G1:   nextOf = ST_Y1;
      ST_Y1:   nextOf = ST_AR1;
      ST_AR1:  nextOf = ST_G2;
      ST_G2:   nextOf = ST_Y2;
      ST_Y2:   nextOf = ST_AR2;
      default: nextOf = ST_G1;
    endcase
  endfunction

  function automatic logic [5:0] lampsOf(input state_e s, input logic b);
    case (s)
      ST_G1:   lampsOf = 6'b001_100;
      ST_Y1:   lampsOf = 6'b010_100;
      ST_AR1:  lampsOf = 6'b100_100;
      ST_G2:   lampsOf = 6'b100_001;
      ST_Y2:   lampsOf = 6'b100_010;
      ST_AR2:  lampsOf = 6'b100_100;
      default: lampsOf = {1'b0, b, 1'b0, 1'b0, b, 1'b0};
    endcase
  endfunction

  function automatic logic [7:0] segCode(input logic [3:0] d);
    case (d)
      4'd0:    segCode = 8'h3F;
      4'd1:    segCode = 8'h06;
      4'd2:    segCode = 8'h5B;
      4'd3:    segCode = 8'h4F;
      4'd4:    segCode = 8'h66;
      4'd5:    segCode = 8'h6D;
      4'd6:    segCode = 8'h7D;
      4'd7:    segCode = 8'h07;
      4'd8:    segCode = 8'h7F;
      4'd9:    segCode = 8'h6F;
      default: segCode = 8'h00;
    endcase
  endfunction

  assign tick = (presc_q == PW'(CLK_DIV - 1));

  // One-second prescaler and display scan timing; both restart on Reset so the
  // first tick lands exactly CLK_DIV cycles after Reset falls.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      presc_q   <= '0;
      scanCnt_q <= '0;
      scan_q    <= 2'd0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (scanCnt_q == SW'(SCAN_DIV - 1)) begin
        scanCnt_q <= '0;
        scan_q    <= scan_q + 2'd1;
      end else begin
        scanCnt_q <= scanCnt_q + 1'b1;
      end
    end
  end

  // Next-state priority: Night, then leaving NIGHT, then pedestrian
  // truncation (beats a coincident tick), then the normal tick countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blink_d = blink_q;
    if (Night) begin
      state_d = ST_NIGHT;
      if (state_q != ST_NIGHT) begin
        blink_d = 1'b0;
      end else if (tick) begin
        blink_d = ~blink_q;
      end
    end else if (state_q == ST_NIGHT) begin
      state_d = ST_AR2;
      cnt_d   = 7'(ALL_RED_T);
      blink_d = 1'b0;
    end else if (((state_q == ST_G1 && Ped_req[0]) || (state_q == ST_G2 && Ped_req[1]))
                 && (cnt_q > 7'(PED_MIN))) begin
      cnt_d = 7'(PED_MIN);
    end else if (tick) begin
      if (cnt_q > 7'd1) begin
        cnt_d = cnt_q - 7'd1;
      end else begin
        state_d = nextOf(state_q);
        cnt_d   = durOf(nextOf(state_q));
      end
    end
  end

  // Lamps are registered from the next state so they change on the same edge
  // as the state register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_G1;
      cnt_q   <= 7'(GREEN1_T);
      blink_q <= 1'b0;
      lamps_q <= LAMPS_G1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
      lamps_q <= lampsOf(state_d, blink_d);
    end
  end

  assign {Red1, Yellow1, Green1, Red2, Yellow2, Green2} = lamps_q;

  // Display: digit 3 tens, digit 2 units, digit 1 blank, digit 0 phase number.
  logic [7:0] segRaw;
  logic [3:0] tensDigit, unitDigit, phaseNum;

  assign tensDigit = 4'(cnt_q / 7'd10);
  assign unitDigit = 4'(cnt_q % 7'd10);
  assign phaseNum  = 4'({1'b0, state_q} + 4'd1);

  always_comb begin
    segRaw = 8'h00;
    if (state_q != ST_NIGHT) begin
      case (scan_q)
        2'd3:    segRaw = segCode(tensDigit);
        2'd2:    segRaw = segCode(unitDigit);
        2'd1:    segRaw = 8'h00;
        default: segRaw = segCode(phaseNum);
      endcase
    end
  end

  assign Seg = (SEG_ACTIVE_LOW != 0) ? ~segRaw : segRaw;
  assign Sl  = 4'b0001 << scan_q;

endmodule

// File: tb/tb_traf_ctl_gen.sv
// tb_traf_ctl_gen
//   Scoreboard bench for traf_ctl_gen. A reference model works in terms of
//   seconds remaining, phase numbers and elapsed cycles since reset. It pushes
//   the expected outputs for every clock edge into a queue. A monitor on the
//   falling edge pops them and compares them against two DUT instances, one
//   with active-high segments and one with active-low segments.
module tb_traf_ctl_gen;

  localparam int CLK_DIV   = 4;
  localparam int GREEN1_T  = 5;
  localparam int GREEN2_T  = 3;
  localparam int YELLOW_T  = 2;
  localparam int ALL_RED_T = 1;
  localparam int PED_MIN   = 2;
  localparam int SCAN_DIV  = 2;

  localparam logic [7:0] SEGTAB [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                         8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  typedef struct {
    logic [5:0] lamps;
    logic [3:0] sl;
    logic [7:0] seg;
    bit         night;
  } expT;

  logic       Clk = 1'b0;
  logic       Reset, Night;
  logic [1:0] Ped_req;
  logic       Red1, Yellow1, Green1, Red2, Yellow2, Green2;
  logic [7:0] Seg, SegLow;
  logic [3:0] Sl, SlLow;
  logic       r1L, y1L, g1L, r2L, y2L, g2L;

  int checks = 0;
  int errors = 0;
  expT expQ[$];

  always #5 Clk = ~Clk;

  traf_ctl_gen #(
    .CLK_DIV(CLK_DIV), .GREEN1_T(GREEN1_T), .GREEN2_T(GREEN2_T),
    .YELLOW_T(YELLOW_T), .ALL_RED_T(ALL_RED_T), .PED_MIN(PED_MIN),
    .SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(0)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Night(Night), .Ped_req(Ped_req),
    .Red1(Red1), .Yellow1(Yellow1), .Green1(Green1),
    .Red2(Red2), .Yellow2(Yellow2), .Green2(Green2),
    .Seg(Seg), .Sl(Sl)
  );

  traf_ctl_gen #(
    .CLK_DIV(CLK_DIV), .GREEN1_T(GREEN1_T), .GREEN2_T(GREEN2_T),
    .YELLOW_T(YELLOW_T), .ALL_RED_T(ALL_RED_T), .PED_MIN(PED_MIN),
    .SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(1)
  ) dutLow (
    .Clk(Clk), .Reset(Reset), .Night(Night), .Ped_req(Ped_req),
    .Red1(r1L), .Yellow1(y1L), .Green1(g1L),
    .Red2(r2L), .Yellow2(y2L), .Green2(g2L),
    .Seg(SegLow), .Sl(SlLow)
  );

  // Reference model state: phase 1..6 (0 = night), whole seconds remaining,
  // cycles elapsed since the last reset edge, and the night blink level.
  int mPhase, mSec, mCyc;
  bit mBlink, mValid = 0;

  function automatic int durOfPhase(input int ph);
    case (ph)
      1:       return GREEN1_T;
      2, 5:    return YELLOW_T;
      4:       return GREEN2_T;
      default: return ALL_RED_T;
    endcase
  endfunction

  function automatic expT expectNow();
    expT e;
    int scan;
    scan    = (mCyc / SCAN_DIV) % 4;
    e.sl    = 4'(1 << scan);
    e.night = (mPhase == 0);
    case (mPhase)
      1:       e.lamps = 6'b001_100;
      2:       e.lamps = 6'b010_100;
      3, 6:    e.lamps = 6'b100_100;
      4:       e.lamps = 6'b100_001;
      5:       e.lamps = 6'b100_010;
      default: e.lamps = {1'b0, mBlink, 1'b0, 1'b0, mBlink, 1'b0};
    endcase
    if (mPhase == 0)    e.seg = 8'h00;
    else if (scan == 3) e.seg = SEGTAB[mSec / 10];
    else if (scan == 2) e.seg = SEGTAB[mSec % 10];
    else if (scan == 1) e.seg = 8'h00;
    else                e.seg = SEGTAB[mPhase];
    return e;
  endfunction

  // Model: advance one clock edge using the inputs present at that edge.
  always @(posedge Clk) begin
    bit tickNow;
    if (Reset) begin
      mPhase = 1; mSec = GREEN1_T; mCyc = 0; mBlink = 0; mValid = 1;
    end else if (mValid) begin
      tickNow = ((mCyc % CLK_DIV) == CLK_DIV - 1);
      mCyc++;
      if (Night) begin
        if (mPhase != 0) begin
          mPhase = 0; mBlink = 0;
        end else if (tickNow) begin
          mBlink = ~mBlink;
        end
      end else if (mPhase == 0) begin
        mPhase = 6; mSec = ALL_RED_T;
      end else if (((mPhase == 1 && Ped_req[0]) || (mPhase == 4 && Ped_req[1]))
                   && mSec > PED_MIN) begin
        mSec = PED_MIN;
      end else if (tickNow) begin
        if (mSec > 1) begin
          mSec--;
        end else begin
          mPhase = (mPhase % 6) + 1;
          mSec   = durOfPhase(mPhase);
        end
      end
    end
    if (mValid) expQ.push_back(expectNow());
  end

  task automatic checkOutput(input expT e);
    logic [5:0] act;
    act = {Red1, Yellow1, Green1, Red2, Yellow2, Green2};
    checks++;
    if (act !== e.lamps) begin
      errors++;
      $display("[TB] FAIL lamps t=%0t got %b expected %b", $time, act, e.lamps);
    end
    checks++;
    if (Sl !== e.sl) begin
      errors++;
      $display("[TB] FAIL sl t=%0t got %b expected %b", $time, Sl, e.sl);
    end
    checks++;
    if (Seg !== e.seg) begin
      errors++;
      $display("[TB] FAIL seg t=%0t got %h expected %h", $time, Seg, e.seg);
    end
    checks++;
    if (SegLow !== ~e.seg) begin
      errors++;
      $display("[TB] FAIL segLow t=%0t got %h expected %h", $time, SegLow, ~e.seg);
    end
    if (!e.night) begin
      checks++;
      if ((Red1 + Yellow1 + Green1) != 1 || (Red2 + Yellow2 + Green2) != 1
          || (Green1 && Green2)) begin
        errors++;
        $display("[TB] FAIL oneHot t=%0t got %b expected one lamp per road", $time, act);
      end
    end
  endtask

  // Monitor: every clock presents a fresh output set; compare mid-cycle.
  always @(negedge Clk) begin
    if (expQ.size() > 0) checkOutput(expQ.pop_front());
  end

  task automatic applyStimulus(input logic r, input logic n, input logic [1:0] p,
                               input int cycles);
    Reset = r; Night = n; Ped_req = p;
    repeat (cycles) @(posedge Clk);
    #2;
  endtask

  initial begin
    bit nightLvl;
    // Reset then one full free-running cycle of all six phases.
    applyStimulus(1, 0, 2'b00, 2);
    applyStimulus(0, 0, 2'b00, 60);
    // Pedestrian request on road 1 coincident with the first tick, then held
    // at cnt=2, followed by a road-2 request while in G1.
    applyStimulus(1, 0, 2'b00, 2);
    applyStimulus(0, 0, 2'b00, 3);
    applyStimulus(0, 0, 2'b01, 6);
    applyStimulus(0, 0, 2'b00, 50);
    applyStimulus(0, 0, 2'b10, 10);
    applyStimulus(0, 0, 2'b00, 10);
    // Night entered mid-G2, then released.
    applyStimulus(1, 0, 2'b00, 2);
    applyStimulus(0, 0, 2'b00, 38);
    applyStimulus(0, 1, 2'b00, 17);
    applyStimulus(0, 0, 2'b00, 30);
    // Reset in Y2, then reset while in night with Night still asserted.
    applyStimulus(1, 0, 2'b00, 1);
    applyStimulus(0, 0, 2'b00, 47);
    applyStimulus(1, 0, 2'b00, 1);
    applyStimulus(0, 0, 2'b00, 5);
    applyStimulus(0, 1, 2'b00, 10);
    applyStimulus(1, 1, 2'b00, 1);
    applyStimulus(0, 0, 2'b00, 12);
    // Randomized traffic: rare resets, slowly toggling night, random requests.
    nightLvl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) nightLvl = ~nightLvl;
      applyStimulus(($urandom_range(0, 299) == 0), nightLvl,
                    ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00, 1);
    end
    applyStimulus(0, 0, 2'b00, 3);
    @(negedge Clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain got %0d expected 0 pending", expQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
